// File: rtl/platform_span_render_pkg.sv
// Shared constants and state encoding for the platform span renderer and the
// bug/collision logic that reuses the platform row window.
package platform_span_render_pkg;

  localparam int POS_W      = 15;
  localparam int LEN_W      = 8;
  localparam int SCREEN_W   = 640;
  localparam int EDGE       = 8;
  localparam int LEN_MIN    = 32;
  localparam int LEN_BITS   = 7;
  localparam int PLAT_TOP   = 400;
  localparam int PLAT_THICK = 8;

  typedef enum logic [1:0] {
    ST_HIDDEN   = 2'd0,
    ST_ENTERING = 2'd1,
    ST_ON       = 2'd2,
    ST_LEAVING  = 2'd3
  } plat_state_t;

  // Visibility of a span is a pure function of its edges, so any wrap lands in
  // HIDDEN or ENTERING without needing transition rules.
  function automatic plat_state_t classify_span(input logic [POS_W-1:0] left,
                                                input logic [POS_W-1:0] right);
    plat_state_t st;
    if (left >= POS_W'(SCREEN_W))       st = ST_HIDDEN;
    else if (right >= POS_W'(SCREEN_W)) st = ST_ENTERING;
    else if (left >= POS_W'(EDGE))      st = ST_ON;
    else                                st = ST_LEAVING;
    return st;
  endfunction

endpackage

// File: rtl/platform_span_snap.sv
// Per-frame snapshot of the platform span: delays Frame so the decremented
// Hupper is used, detects counter reloads, and latches length/edges/state.
module platform_span_snap
  import platform_span_render_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_frame,
  input  logic [POS_W-1:0]    i_hupper,
  input  logic [LEN_BITS-1:0] i_rand_lsb,
  output logic                o_frame_d,
  output logic [POS_W-1:0]    o_plat_left,
  output logic [POS_W-1:0]    o_plat_right,
  output logic [LEN_W-1:0]    o_plat_len,
  output plat_state_t         o_state,
  output logic                o_new_plat
);

  logic             r_frame_d;
  logic             r_seen;
  logic             r_new_plat;
  logic [POS_W-1:0] r_prev_h;
  logic [POS_W-1:0] r_left;
  logic [POS_W-1:0] r_right;
  logic [LEN_W-1:0] r_len;
  plat_state_t      r_state;
  plat_state_t      w_state_next;

  logic             w_wrap;
  logic [LEN_W-1:0] w_len;
  logic [POS_W-1:0] w_len_ext;
  logic [POS_W-1:0] w_left;

  // A rising Hupper means the border counter reloaded; the first frame after
  // reset is treated the same way so a length is always drawn from rand.
  always_comb begin
    w_wrap    = !r_seen || (i_hupper > r_prev_h);
    w_len     = w_wrap ? (LEN_W'(LEN_MIN) + LEN_W'(i_rand_lsb)) : r_len;
    w_len_ext = POS_W'(w_len);
    w_left    = (i_hupper >= w_len_ext) ? (i_hupper - w_len_ext) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_d  <= 1'b0;
      r_seen     <= 1'b0;
      r_new_plat <= 1'b0;
      r_prev_h   <= '0;
      r_left     <= '0;
      r_right    <= '0;
      r_len      <= LEN_W'(LEN_MIN);
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_frame_d  <= i_frame;
      r_new_plat <= r_frame_d && w_wrap;
      if (r_frame_d) begin
        r_seen   <= 1'b1;
        r_prev_h <= i_hupper;
        r_right  <= i_hupper;
        r_left   <= w_left;
        r_len    <= w_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_HIDDEN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block combinational (no latch).
    w_state_next = r_state;
    if (r_frame_d) w_state_next = classify_span(w_left, i_hupper);
  end

  assign o_frame_d    = r_frame_d;
  assign o_plat_left  = r_left;
  assign o_plat_right = r_right;
  assign o_plat_len   = r_len;
  assign o_state      = r_state;
  assign o_new_plat   = r_new_plat;

endmodule

// File: rtl/platform_span_render.sv
// Platform span renderer: registered per-pixel draw signal and per-frame
// bug-on-platform flag. Define PLAT_BLINK_EN to blink the platform while LEAVING.
module platform_span_render
  import platform_span_render_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_frame,
  input  logic [POS_W-1:0] i_hupper,
  input  logic [POS_W-1:0] i_rand,
  input  logic [9:0]       i_hpix,
  input  logic [9:0]       i_vpix,
  input  logic             i_bug_px,
  output logic             o_plat_px,
  output logic [POS_W-1:0] o_plat_left,
  output logic [POS_W-1:0] o_plat_right,
  output logic [LEN_W-1:0] o_plat_len,
  output logic [1:0]       o_state,
  output logic             o_new_plat,
  output logic             o_on_platform
);

  logic             w_frame_d;
  plat_state_t      w_state;
  logic [POS_W-1:0] w_left;
  logic [POS_W-1:0] w_right;
  logic [POS_W-1:0] w_hpix_ext;
  logic             w_row;
  logic             w_span;
  logic             w_unused_rand;

  logic r_span;
  logic r_bug_d;
  logic r_hit;
  logic r_on_platform;

  platform_span_snap u_snap (
    .clk          (clk),
    .reset        (reset),
    .i_frame      (i_frame),
    .i_hupper     (i_hupper),
    .i_rand_lsb   (i_rand[LEN_BITS-1:0]),
    .o_frame_d    (w_frame_d),
    .o_plat_left  (w_left),
    .o_plat_right (w_right),
    .o_plat_len   (o_plat_len),
    .o_state      (w_state),
    .o_new_plat   (o_new_plat)
  );

  assign w_unused_rand = ^i_rand[POS_W-1:LEN_BITS];

  assign w_hpix_ext = POS_W'(i_hpix);
  assign w_row  = (i_vpix >= 10'(PLAT_TOP)) && (i_vpix < 10'(PLAT_TOP + PLAT_THICK));
  assign w_span = (w_state != ST_HIDDEN) && w_row &&
                  (w_hpix_ext >= w_left) && (w_hpix_ext < w_right);

  // bug_px is delayed to line up with the registered span; a frame boundary
  // clear takes priority over a hit landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_span        <= 1'b0;
      r_bug_d       <= 1'b0;
      r_hit         <= 1'b0;
      r_on_platform <= 1'b0;
    end else begin
      r_span  <= w_span;
      r_bug_d <= i_bug_px;
      if (w_frame_d) begin
        r_on_platform <= r_hit;
        r_hit         <= 1'b0;
      end else if (r_span && r_bug_d) begin
        r_hit <= 1'b1;
      end
    end
  end

`ifdef PLAT_BLINK_EN
  logic [3:0] r_blink_cnt;
  logic       r_plat_px;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_plat_px   <= 1'b0;
    end else begin
      if (w_frame_d) r_blink_cnt <= r_blink_cnt + 4'd1;
      r_plat_px <= w_span && !((w_state == ST_LEAVING) && r_blink_cnt[2]);
    end
  end

  assign o_plat_px = r_plat_px;
`else
  assign o_plat_px = r_span;
`endif

  assign o_plat_left   = w_left;
  assign o_plat_right  = w_right;
  assign o_state       = w_state;
  assign o_on_platform = r_on_platform;

endmodule

// File: tb/tb_platform_span_render.sv
// Bench for platform_span_render: directed frames/pixels with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_platform_span_render;
  import platform_span_render_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_frame;
  logic [14:0] i_hupper;
  logic [14:0] i_rand;
  logic [9:0]  i_hpix;
  logic [9:0]  i_vpix;
  logic        i_bug_px;
  logic        o_plat_px;
  logic [14:0] o_plat_left;
  logic [14:0] o_plat_right;
  logic [7:0]  o_plat_len;
  logic [1:0]  o_state;
  logic        o_new_plat;
  logic        o_on_platform;

  int checks = 0;
  int errors = 0;

  platform_span_render dut (
    .clk           (clk),
    .reset         (reset),
    .i_frame       (i_frame),
    .i_hupper      (i_hupper),
    .i_rand        (i_rand),
    .i_hpix        (i_hpix),
    .i_vpix        (i_vpix),
    .i_bug_px      (i_bug_px),
    .o_plat_px     (o_plat_px),
    .o_plat_left   (o_plat_left),
    .o_plat_right  (o_plat_right),
    .o_plat_len    (o_plat_len),
    .o_state       (o_state),
    .o_new_plat    (o_new_plat),
    .o_on_platform (o_on_platform)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid = 1'b0;
  int          m_left, m_right, m_prev, m_len, m_cnt;
  logic [1:0]  m_state;
  bit          m_seen, m_frame_d, m_new, m_on, m_hit, m_span, m_px, m_bug_d;

  function automatic logic [1:0] span_state(input int left, input int right);
    if (left >= 640)  return 2'd0;
    if (right >= 640) return 2'd1;
    if (left >= 8)    return 2'd2;
    return 2'd3;
  endfunction

  always @(posedge clk) begin : model_step
    int  t_len, t_left, t_h;
    bit  t_span, t_px, t_wrap;
    if (reset) begin
      m_valid <= 1'b1;
      m_left <= 0; m_right <= 0; m_prev <= 0; m_len <= 32; m_cnt <= 0;
      m_state <= 2'd0; m_seen <= 0; m_frame_d <= 0; m_new <= 0;
      m_on <= 0; m_hit <= 0; m_span <= 0; m_px <= 0; m_bug_d <= 0;
    end else begin
      t_span = (m_state != 2'd0) && (int'(i_vpix) >= 400) && (int'(i_vpix) < 408) &&
               (int'(i_hpix) >= m_left) && (int'(i_hpix) < m_right);
      t_px = t_span;
`ifdef PLAT_BLINK_EN
      if (m_state == 2'd3 && ((m_cnt / 4) % 2 == 1)) t_px = 1'b0;
`endif
      m_span  <= t_span;
      m_px    <= t_px;
      m_bug_d <= i_bug_px;
      m_new   <= 1'b0;
      if (m_frame_d) begin
        m_on  <= m_hit;
        m_hit <= 1'b0;
        t_h    = int'(i_hupper);
        t_wrap = !m_seen || (t_h > m_prev);
        t_len  = t_wrap ? 32 + (int'(i_rand) % 128) : m_len;
        t_left = t_h - t_len;
        if (t_left < 0) t_left = 0;
        m_new   <= t_wrap;
        m_len   <= t_len;
        m_left  <= t_left;
        m_right <= t_h;
        m_prev  <= t_h;
        m_seen  <= 1'b1;
        m_state <= span_state(t_left, t_h);
        m_cnt   <= (m_cnt + 1) % 16;
      end else if (m_span && m_bug_d) begin
        m_hit <= 1'b1;
      end
      m_frame_d <= i_frame;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_plat_px",    32'(o_plat_px),     32'(m_px));
      check("cyc_plat_left",  32'(o_plat_left),   32'(m_left));
      check("cyc_plat_right", 32'(o_plat_right),  32'(m_right));
      check("cyc_plat_len",   32'(o_plat_len),    32'(m_len));
      check("cyc_state",      32'(o_state),       32'(m_state));
      check("cyc_new_plat",   32'(o_new_plat),    32'(m_new));
      check("cyc_on_plat",    32'(o_on_platform), 32'(m_on));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_frame(input logic [14:0] h, input logic [14:0] r, output logic new_seen);
    i_frame = 1'b1;
    i_rand  = r;
    @(negedge clk);
    i_frame  = 1'b0;
    i_hupper = h;
    @(negedge clk);
    new_seen = o_new_plat;
  endtask

  task automatic pixel(input int h, input int v, input logic bug, output logic px);
    i_hpix   = 10'(h);
    i_vpix   = 10'(v);
    i_bug_px = bug;
    @(negedge clk);
    px       = o_plat_px;
    i_bug_px = 1'b0;
    i_vpix   = 10'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic nw, px;
    int   ones;
    reset = 1'b1; i_frame = 0; i_hupper = 0; i_rand = 0;
    i_hpix = 0; i_vpix = 0; i_bug_px = 0;
    repeat (3) @(negedge clk);
    check("rst_len",   32'(o_plat_len), 32);
    check("rst_state", 32'(o_state), 0);
    check("rst_left",  32'(o_plat_left), 0);
    reset = 1'b0;

    do_frame(15'd908, 15'h0005, nw);
    check("f1_new",   32'(nw), 1);
    check("f1_len",   32'(o_plat_len), 37);
    check("f1_left",  32'(o_plat_left), 871);
    check("f1_state", 32'(o_state), 0);

    do_frame(15'd660, 15'h0000, nw);
    check("f2_new",   32'(nw), 0);
    check("f2_left",  32'(o_plat_left), 623);
    check("f2_state", 32'(o_state), 1);
    pixel(630, 403, 0, px); check("px_630_403", 32'(px), 1);
    pixel(639, 403, 0, px); check("px_639_403", 32'(px), 1);
    pixel(630, 408, 0, px); check("px_630_408", 32'(px), 0);
    pixel(622, 403, 0, px); check("px_622_403", 32'(px), 0);

    do_frame(15'd300, 15'h0000, nw);
    check("f3_new",   32'(nw), 0);
    check("f3_left",  32'(o_plat_left), 263);
    check("f3_state", 32'(o_state), 2);
    pixel(263, 400, 0, px); check("px_263", 32'(px), 1);
    pixel(300, 400, 0, px); check("px_300", 32'(px), 0);

    pixel(280, 400, 1, px); check("hit_px", 32'(px), 1);
    do_frame(15'd300, 15'h0000, nw);
    check("hit_on1", 32'(o_on_platform), 1);
    do_frame(15'd300, 15'h0000, nw);
    check("hit_on0", 32'(o_on_platform), 0);

    do_frame(15'd20, 15'h0000, nw);
    check("low_left",  32'(o_plat_left), 0);
    check("low_state", 32'(o_state), 3);
    do_frame(15'd908, 15'h7FFF, nw);
    check("wrap_new",   32'(nw), 1);
    check("wrap_len",   32'(o_plat_len), 159);
    check("wrap_left",  32'(o_plat_left), 749);
    check("wrap_state", 32'(o_state), 0);

    // back-to-back Frame pulses: two consecutive snapshots
    i_frame = 1'b1; @(negedge clk);
    i_hupper = 15'd700; @(negedge clk);
    check("b2b_left1", 32'(o_plat_left), 541);
    i_frame = 1'b0; i_hupper = 15'd650; @(negedge clk);
    check("b2b_left2",  32'(o_plat_left), 491);
    check("b2b_state",  32'(o_state), 1);
    check("b2b_nonew",  32'(o_new_plat), 0);

    ones = 0;
    for (int k = 0; k < 8; k++) begin
      do_frame(15'(100 - k), 15'h0000, nw);
      check("lv_state", 32'(o_state), 3);
      pixel(50, 400, 0, px);
      if (px) ones++;
    end
`ifdef PLAT_BLINK_EN
    check("lv_blink_ones", 32'(ones), 4);
`else
    check("lv_solid_ones", 32'(ones), 8);
`endif

    // reset in the middle of a frame
    do_frame(15'd300, 15'h0000, nw);
    i_frame = 1'b1; i_hupper = 15'd290;
    i_hpix = 10'd280; i_vpix = 10'd400;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mr_px",    32'(o_plat_px), 0);
    check("mr_left",  32'(o_plat_left), 0);
    check("mr_right", 32'(o_plat_right), 0);
    check("mr_len",   32'(o_plat_len), 32);
    check("mr_state", 32'(o_state), 0);
    check("mr_new",   32'(o_new_plat), 0);
    check("mr_on",    32'(o_on_platform), 0);
    reset = 1'b0; i_frame = 1'b0; i_vpix = 10'd0;
    @(negedge clk);

    do_frame(15'd908, 15'h0005, nw);
    check("pr_new", 32'(nw), 1);
    check("pr_len", 32'(o_plat_len), 37);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
